// File: rtl/mnd_pkg.sv
// Shared phase type and counter sizing helper for the domino NAND bank.
package mnd_pkg;

    typedef enum logic [1:0] {PH_IDLE, PH_PRE, PH_EVAL} phase_e;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mnd_domino_bank_if.sv
// Control/data bundle for mnd_domino_bank; slave modport is the bank side.
interface mnd_domino_bank_if #(
    parameter int unsigned CH = 4,
    parameter int unsigned W  = 3
);
    logic            start;
    logic            foot_en;
    logic [CH*W-1:0] a;
    logic            busy;
    logic [CH-1:0]   dyn;
    logic            done;
    logic [CH-1:0]   out;
    logic [CH-1:0]   mono_err;
    logic [CH-1:0]   leak_err;

    modport master (
        output start, foot_en, a,
        input  busy, dyn, done, out, mono_err, leak_err
    );

    modport slave (
        input  start, foot_en, a,
        output busy, dyn, done, out, mono_err, leak_err
    );
endinterface

// File: rtl/mnd_dyn_node.sv
// One footed dynamic NAND node with monotonicity check.
// MND_KEEPER_EN defined: keeper holds the node, no leak counter is built.
module mnd_dyn_node
    import mnd_pkg::*;
#(
    parameter int unsigned W        = 3,
    parameter int unsigned LEAK_CYC = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  phase_e       phase,
    input  logic         accept,
    input  logic         last_eval,
    input  logic [W-1:0] a,
    input  logic         foot_en,
    output logic         dyn,
    output logic         dyn_eval,
    output logic         mono_err,
    output logic         leak_err
);
    logic         dyn_q;
    logic [W-1:0] a_prev_q;
    logic         mono_q;
    logic         eval;
    logic         discharge;
    logic         fall;
    logic         leak_fire;

    assign eval      = (phase == PH_EVAL);
    assign discharge = eval && dyn_q && (&a) && foot_en;
    assign fall      = eval && ((a_prev_q & ~a) != '0);
    assign dyn_eval  = dyn_q && !discharge && !leak_fire;

`ifdef MND_KEEPER_EN
    assign leak_fire = 1'b0;
    assign leak_err  = 1'b0;
`else
    localparam int unsigned LW = $clog2(LEAK_CYC + 1);
    logic [LW-1:0] leak_cnt_q, leak_cnt_d;
    logic          leak_q;

    // Run length of undischarged EVAL cycles; any other phase restarts it.
    always_comb begin
        leak_cnt_d = '0;
        leak_fire  = 1'b0;
        if (eval && dyn_q && !discharge) begin
            leak_cnt_d = leak_cnt_q + 1'b1;
            leak_fire  = (leak_cnt_d == LW'(LEAK_CYC));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leak_cnt_q <= '0;
            leak_q     <= 1'b0;
        end else begin
            leak_cnt_q <= leak_fire ? '0 : leak_cnt_d;
            if (accept) begin
                leak_q <= 1'b0;
            end else if (leak_fire) begin
                leak_q <= 1'b1;
            end
        end
    end

    assign leak_err = leak_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dyn_q    <= 1'b1;
            a_prev_q <= '0;
            mono_q   <= 1'b0;
        end else begin
            // The node returns high as soon as evaluation ends.
            dyn_q    <= (eval && !last_eval) ? dyn_eval : 1'b1;
            a_prev_q <= a;
            if (accept) begin
                mono_q <= 1'b0;
            end else if (fall) begin
                mono_q <= 1'b1;
            end
        end
    end

    assign dyn      = dyn_q;
    assign mono_err = mono_q;
endmodule

// File: rtl/mnd_domino_bank.sv
// Bank of CH footed dynamic NAND nodes sharing one precharge/evaluate controller.
// MND_KEEPER_EN selects the kept-node model (no leak decay, LEAK_ERR tied low).
module mnd_domino_bank
    import mnd_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned W        = 3,
    parameter int unsigned PRE_CYC  = 2,
    parameter int unsigned EVAL_CYC = 4,
    parameter int unsigned LEAK_CYC = 8
) (
    input  logic              ck,
    input  logic              rst,
    mnd_domino_bank_if.slave  bus
);
    localparam int unsigned CntW =
        cnt_width((PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC);

    phase_e          phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;
    logic            last_eval;
    logic            done_q;
    logic [CH-1:0]   out_q;
    logic [CH-1:0]   dyn;
    logic [CH-1:0]   dyn_eval;
    logic [CH-1:0]   mono_err;
    logic [CH-1:0]   leak_err;

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        last_eval = 1'b0;
        unique case (phase_q)
            PH_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    phase_d = PH_PRE;
                    cnt_d   = '0;
                end
            end
            PH_PRE: begin
                if (cnt_q == CntW'(PRE_CYC - 1)) begin
                    phase_d = PH_EVAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PH_EVAL: begin
                if (cnt_q == CntW'(EVAL_CYC - 1)) begin
                    last_eval = 1'b1;
                    phase_d   = PH_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                phase_d = PH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '1;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            done_q  <= last_eval;
            // Capture includes the discharge happening in the final EVAL cycle.
            if (last_eval) begin
                out_q <= dyn_eval;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_node
        mnd_dyn_node #(
            .W        (W),
            .LEAK_CYC (LEAK_CYC)
        ) u_node (
            .clk       (ck),
            .rst       (rst),
            .phase     (phase_q),
            .accept    (accept),
            .last_eval (last_eval),
            .a         (bus.a[c*W +: W]),
            .foot_en   (bus.foot_en),
            .dyn       (dyn[c]),
            .dyn_eval  (dyn_eval[c]),
            .mono_err  (mono_err[c]),
            .leak_err  (leak_err[c])
        );
    end

    assign bus.busy     = (phase_q != PH_IDLE);
    assign bus.done     = done_q;
    assign bus.out      = out_q;
    assign bus.dyn      = dyn;
    assign bus.mono_err = mono_err;
    assign bus.leak_err = leak_err;
endmodule

// File: tb/tb_mnd_domino_bank.sv
// Randomized bench for mnd_domino_bank against an operation-level reference model.
module tb_mnd_domino_bank;
    localparam int unsigned CH     = 4;
    localparam int unsigned W      = 3;
    localparam int unsigned PRE    = 2;
    localparam int unsigned EVAL   = 4;
    localparam int unsigned LEAK   = 8;
    localparam int unsigned EVAL_L = 12;
    localparam int unsigned NCYC   = 1 + PRE + EVAL;
    localparam logic [CH-1:0] Ones = '1;
`ifdef MND_KEEPER_EN
    localparam bit Keeper = 1'b1;
`else
    localparam bit Keeper = 1'b0;
`endif

    logic ck = 1'b0;
    logic rst;
    always #5 ck = ~ck;

    mnd_domino_bank_if #(.CH(CH), .W(W)) bus ();
    mnd_domino_bank_if #(.CH(CH), .W(W)) bus_l ();

    mnd_domino_bank #(
        .CH(CH), .W(W), .PRE_CYC(PRE), .EVAL_CYC(EVAL), .LEAK_CYC(LEAK)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    mnd_domino_bank #(
        .CH(CH), .W(W), .PRE_CYC(PRE), .EVAL_CYC(EVAL_L), .LEAK_CYC(LEAK)
    ) dut_leak (
        .ck  (ck),
        .rst (rst),
        .bus (bus_l)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [CH*W-1:0] stim_a [NCYC];
    logic            stim_f [NCYC];
    logic [CH-1:0]   exp_out, exp_mono, exp_leak;
    bit              done_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Node is gone after eval cycle k if it discharged or decayed by then.
    function automatic bit gone(input int fd, input int la, input int k);
        return (fd != 0 && k >= fd) || (la != 0 && k >= la);
    endfunction

    function automatic logic [CH*W-1:0] rand_a();
        return (CH*W)'($urandom);
    endfunction

    task automatic fill(input logic [CH*W-1:0] av, input logic f);
        for (int i = 0; i < NCYC; i++) begin
            stim_a[i] = av;
            stim_f[i] = f;
        end
    endtask

    task automatic gen_random();
        int fmode;
        int mode;
        logic [W-1:0] v;
        fmode = int'($urandom_range(0, 3));
        for (int c = 0; c < CH; c++) begin
            mode = int'($urandom_range(0, 2));
            v = ($urandom_range(0, 1) != 0) ? '1 : W'($urandom);
            for (int i = 0; i < NCYC; i++) begin
                if (mode == 1) v = v | (W'($urandom) & W'($urandom));
                else if (mode == 2) v = W'($urandom);
                stim_a[i][c*W +: W] = v;
            end
        end
        for (int i = 0; i < NCYC; i++) begin
            stim_f[i] = (fmode == 0) ? 1'b0 : (fmode == 1) ? 1'($urandom) : 1'b1;
        end
    endtask

    // start_mode while busy: 0 low, 1 high, 2 random
    task automatic run_op(input int start_mode);
        logic [CH-1:0] e_out, e_mono, e_leak, ed;
        logic [W-1:0]  av, pv;
        int first_dis [CH];
        int leak_at [CH];
        int k;
        for (int c = 0; c < CH; c++) begin
            first_dis[c] = 0;
            e_mono[c] = 1'b0;
            for (int e = 1; e <= EVAL; e++) begin
                av = stim_a[PRE+e][c*W +: W];
                pv = stim_a[PRE+e-1][c*W +: W];
                if (first_dis[c] == 0 && (&av) && stim_f[PRE+e]) first_dis[c] = e;
                if ((pv & ~av) != '0) e_mono[c] = 1'b1;
            end
            leak_at[c] = (!Keeper && EVAL >= LEAK &&
                          (first_dis[c] == 0 || first_dis[c] > LEAK)) ? LEAK : 0;
            e_leak[c] = (leak_at[c] != 0);
            e_out[c]  = !gone(first_dis[c], leak_at[c], EVAL);
        end
        for (int i = 0; i < NCYC; i++) begin
            bus.a       = stim_a[i];
            bus.foot_en = stim_f[i];
            bus.start   = (i == 0) ? 1'b1 :
                          (start_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(start_mode);
            if (i == 0) begin
                check("acc_busy", bus.busy, 0);
                check("acc_dyn", bus.dyn, Ones);
                check("done", bus.done, done_pending);
                check("out_hold", bus.out, exp_out);
                check("mono_err", bus.mono_err, exp_mono);
                check("leak_err", bus.leak_err, exp_leak);
                done_pending = 1'b0;
            end else if (i <= PRE) begin
                check("pre_busy", bus.busy, 1);
                check("pre_dyn", bus.dyn, Ones);
                check("pre_done", bus.done, 0);
                check("pre_mono_clr", bus.mono_err, 0);
                check("pre_leak_clr", bus.leak_err, 0);
            end else begin
                k = i - PRE;
                for (int c = 0; c < CH; c++) ed[c] = !gone(first_dis[c], leak_at[c], k - 1);
                check("eval_dyn", bus.dyn, ed);
                check("eval_busy", bus.busy, 1);
                check("eval_out_hold", bus.out, exp_out);
            end
            tick();
        end
        exp_out      = e_out;
        exp_mono     = e_mono;
        exp_leak     = e_leak;
        done_pending = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.start   = 1'b0;
            bus.a       = rand_a();
            bus.foot_en = 1'($urandom);
            check("idle_busy", bus.busy, 0);
            check("idle_dyn", bus.dyn, Ones);
            check("idle_done", bus.done, done_pending);
            check("idle_out", bus.out, exp_out);
            check("idle_mono", bus.mono_err, exp_mono);
            check("idle_leak", bus.leak_err, exp_leak);
            done_pending = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.foot_en = 1'b0; bus.a = '0;
        bus_l.start = 1'b0; bus_l.foot_en = 1'b0; bus_l.a = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dyn", bus.dyn, Ones);
        check("rst_out", bus.out, Ones);
        check("rst_mono", bus.mono_err, 0);
        check("rst_leak", bus.leak_err, 0);
        exp_out = Ones; exp_mono = '0; exp_leak = '0; done_pending = 1'b0;

        // All inputs high, foot on: every node discharges.
        fill('1, 1'b1);
        run_op(0);
        check("t1_out", bus.out, 4'b0000);
        idle(1);

        fill(12'b000_000_110_111, 1'b1);
        run_op(0);
        check("t2_out_foot1", bus.out, 4'b1110);
        idle(1);
        fill(12'b000_000_110_111, 1'b0);
        run_op(2);
        check("t2_out_foot0", bus.out, 4'b1111);
        idle(2);

        // Channel 2 high through EVAL 1, then bit 2 falls in EVAL 2.
        fill('0, 1'b1);
        for (int i = 0; i <= PRE + 1; i++) stim_a[i][8:6] = 3'b111;
        for (int i = PRE + 2; i < NCYC; i++) stim_a[i][8:6] = 3'b011;
        run_op(0);
        check("t3_mono", bus.mono_err, 4'b0100);
        check("t3_out", bus.out, 4'b1011);
        idle(1);
        fill(rand_a(), 1'b1);
        run_op(0);
        idle(1);

        // Reset in the first EVAL cycle aborts the op.
        for (int i = 0; i <= PRE + 1; i++) begin
            bus.start = 1'b1; bus.a = '1; bus.foot_en = 1'b1;
            if (i == PRE + 1) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        bus.start = 1'b0;
        check("t5_busy", bus.busy, 0);
        check("t5_dyn", bus.dyn, Ones);
        check("t5_out", bus.out, Ones);
        check("t5_mono", bus.mono_err, 0);
        exp_out = Ones; exp_mono = '0; exp_leak = '0; done_pending = 1'b0;
        idle(NCYC + 3);

        // Continuous START: DONE every NCYC cycles.
        for (int r = 0; r < 3; r++) begin
            gen_random();
            run_op(1);
        end
        idle(1);

        for (int r = 0; r < 40; r++) begin
            gen_random();
            run_op(int'($urandom_range(0, 2)));
            idle(int'($urandom_range(0, 2)));
        end

        // Long evaluate with undischarged inputs on the second bank.
        bus_l.a = '0;
        bus_l.foot_en = 1'b1;
        for (int i = 0; i < 1 + PRE + EVAL_L; i++) begin
            bus_l.start = (i == 0);
            if (i == PRE + 8) check("t4_dyn_e8", bus_l.dyn, Ones);
            if (i == PRE + 9) begin
                check("t4_dyn_e9", bus_l.dyn, Keeper ? Ones : 4'b0000);
                check("t4_leak_e9", bus_l.leak_err, Keeper ? 4'b0000 : Ones);
            end
            tick();
        end
        bus_l.start = 1'b0;
        check("t4_done", bus_l.done, 1);
        check("t4_busy", bus_l.busy, 0);
        check("t4_out", bus_l.out, Keeper ? Ones : 4'b0000);
        check("t4_leak", bus_l.leak_err, Keeper ? 4'b0000 : Ones);
        check("t4_mono", bus_l.mono_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
